// File: rtl/branch_unit.sv
// Branch resolution stage: resolves taken/target for COND/JAL/JALR, registers the
// result into a single output slot, and flags mispredicts with a one-cycle fetch
// redirect followed by a one-cycle flush of the wrong-path instruction.
module branch_unit #(
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    // upstream handshake and operands
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              imm_i,
    input  logic [31:0]              rs1_i,
    input  logic [1:0]               br_kind_i,
    input  logic                     cmp_res_i,
    input  logic                     pred_taken_i,
    input  logic [31:0]              pred_target_i,
    // downstream handshake and result slot
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_pc_o,
    output logic [31:0]              out_link_o,
    output logic                     out_taken_o,
    output logic                     misaligned_o,
    // fetch redirect
    output logic                     redirect_o,
    output logic [31:0]              redirect_pc_o,
    // statistics
    output logic [COUNTER_WIDTH-1:0] branch_count_o,
    output logic [COUNTER_WIDTH-1:0] mispredict_count_o
);

    localparam logic [1:0] KindNone = 2'd0;
    localparam logic [1:0] KindCond = 2'd1;
    localparam logic [1:0] KindJal  = 2'd2;
    localparam logic [1:0] KindJalr = 2'd3;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e state_q, state_d;

    logic                     out_valid_q, out_valid_d;
    logic [31:0]              out_pc_q, out_pc_d;
    logic [31:0]              out_link_q, out_link_d;
    logic                     out_taken_q, out_taken_d;
    logic                     misaligned_q, misaligned_d;
    logic                     redirect_q, redirect_d;
    logic [31:0]              redirect_pc_q, redirect_pc_d;
    logic [COUNTER_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [COUNTER_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    logic        taken;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] actual_next;
    logic [31:0] pred_next;
    logic        mispredict;
    logic        misaligned;
    logic        accept;
    logic        redirect_hit;

    // Resolve the presented instruction: direction, target and prediction check
    always_comb begin
        taken    = 1'b0;
        target   = 32'h0;
        pc_plus4 = pc_i + 32'd4;
        unique case (br_kind_i)
            KindCond: begin
                taken  = cmp_res_i;
                target = pc_i + imm_i;
            end
            KindJal: begin
                taken  = 1'b1;
                target = pc_i + imm_i;
            end
            KindJalr: begin
                taken  = 1'b1;
                target = (rs1_i + imm_i) & 32'hFFFF_FFFE;
            end
            default: begin
                taken  = 1'b0;
                target = 32'h0;
            end
        endcase
        actual_next  = taken ? target : pc_plus4;
        pred_next    = pred_taken_i ? pred_target_i : pc_plus4;
        mispredict   = (actual_next != pred_next);
        misaligned   = taken && (target[1:0] != 2'b00);
        // A misaligned target traps downstream instead of redirecting fetch
        redirect_hit = mispredict && !misaligned;
    end

    // FSM output: during flush the wrong-path instruction is swallowed, so always ready
    always_comb begin
        in_ready_o = 1'b1;
        accept     = 1'b0;
        unique case (state_q)
            StRun: begin
                in_ready_o = !out_valid_q || out_ready_i;
                accept     = in_valid_i && in_ready_o;
            end
            StFlush: begin
                in_ready_o = 1'b1;
                accept     = 1'b0;
            end
            default: begin
                in_ready_o = 1'b1;
                accept     = 1'b0;
            end
        endcase
    end

    // FSM next state: one flush cycle after every redirecting capture
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (accept && redirect_hit) state_d = StFlush;
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Output slot, redirect and counter next-state
    always_comb begin
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_link_d    = out_link_q;
        out_taken_d   = out_taken_q;
        misaligned_d  = misaligned_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            out_pc_d     = pc_i;
            out_link_d   = pc_plus4;
            out_taken_d  = taken;
            misaligned_d = misaligned;
            if (br_kind_i != KindNone) begin
                branch_cnt_d = branch_cnt_q + COUNTER_WIDTH'(1);
            end
            if (redirect_hit) begin
                redirect_d    = 1'b1;
                redirect_pc_d = actual_next;
                mispred_cnt_d = mispred_cnt_q + COUNTER_WIDTH'(1);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StRun;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'h0;
            out_link_q    <= 32'h0;
            out_taken_q   <= 1'b0;
            misaligned_q  <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_link_q    <= out_link_d;
            out_taken_q   <= out_taken_d;
            misaligned_q  <= misaligned_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign out_valid_o        = out_valid_q;
    assign out_pc_o           = out_pc_q;
    assign out_link_o         = out_link_q;
    assign out_taken_o        = out_taken_q;
    assign misaligned_o       = misaligned_q;
    assign redirect_o         = redirect_q;
    assign redirect_pc_o      = redirect_pc_q;
    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispred_cnt_q;

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, width of the branch and mispredict counters.
REQ-002 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-003 SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_valid_i input 1 and in_ready_o output 1, the upstream valid/ready handshake.
REQ-005 SHALL have ports pc_i, imm_i and rs1_i, each input 32: instruction PC, sign-extended immediate and rs1 value.
REQ-006 SHALL have port br_kind_i  input  2  with encoding 0=NONE, 1=COND, 2=JAL, 3=JALR.
REQ-007 SHALL have port cmp_res_i  input  1  the condition result from the compare unit, valid with in_valid_i.
REQ-008 SHALL have ports pred_taken_i input 1 and pred_target_i input 32, the fetch-stage prediction.
REQ-009 SHALL have ports out_valid_o output 1 and out_ready_i input 1, the downstream handshake.
REQ-010 SHALL have ports out_pc_o and out_link_o, each output 32, plus out_taken_o output 1 and misaligned_o output 1.
REQ-011 SHALL have ports redirect_o output 1 and redirect_pc_o output 32, the fetch redirect.
REQ-012 SHALL have ports branch_count_o and mispredict_count_o, each output COUNTER_WIDTH.

Function
REQ-013 SHALL accept an instruction when in_valid_i && in_ready_o, except as in REQ-024.
REQ-014 SHALL drive in_ready_o = !out_valid_o || out_ready_i in state RUN.
REQ-015 SHALL register each accepted instruction into the output slot with 1-cycle latency: out_valid_o rises the cycle after acceptance.
REQ-016 SHALL hold all out_* outputs stable while out_valid_o && !out_ready_i.
REQ-017 SHALL clear out_valid_o when the slot is consumed (out_ready_i high) and no new instruction is accepted in the same cycle.
REQ-018 SHALL compute taken as: COND gives cmp_res_i; JAL and JALR give 1; NONE gives 0.
REQ-019 SHALL compute the target modulo 2^32 as: pc_i+imm_i for COND/JAL; (rs1_i+imm_i) with bit 0 cleared for JALR.
REQ-020 SHALL set the actual next PC to target if taken, else pc_i+4; out_link_o = pc_i+4 (wraps); out_pc_o = pc_i.
REQ-021 SHALL set the predicted next PC to pred_target_i if pred_taken_i, else pc_i+4; it is a mispredict when the actual next PC differs from the predicted next PC.
REQ-022 SHALL assert misaligned_o with the output slot when taken and target[1:0] != 0; a misaligned instruction SHALL NOT redirect.
REQ-023 SHALL, on a non-misaligned mispredict, assert redirect_o for exactly one cycle (the cycle out_valid_o rises), with redirect_pc_o = actual next PC, and enter state FLUSH; redirect_o SHALL be 0 otherwise.
REQ-024 SHALL, in state FLUSH (one cycle only), drive in_ready_o=1 and discard any presented instruction (wrong path): no capture, no counter update; then return to RUN regardless of out_ready_i.
REQ-025 SHALL keep redirect_pc_o at its last value when redirect_o is 0.
REQ-026 SHALL increment branch_count_o for each accepted, non-discarded instruction with br_kind_i != NONE.
REQ-027 SHALL increment mispredict_count_o once per redirect_o pulse.
REQ-028 SHALL let both counters wrap from all-ones to zero.
REQ-029 SHALL use FSM states RUN and FLUSH only: RUN goes to FLUSH on a mispredict capture; FLUSH always goes to RUN.

Reset
REQ-030 SHALL, on reset_ni low at any time (including mid-stall or FLUSH), immediately set: state RUN; out_valid_o, redirect_o, out_taken_o and misaligned_o to 0; all 32-bit outputs to 0; both counters to 0.
REQ-031 SHALL drive in_ready_o=1 after reset deasserts.

Verification
REQ-032 SHALL cover: COND, pc=0x100, imm=0x20, cmp_res=1, pred_taken=0 -> next cycle out_taken=1, redirect=1 with redirect_pc=0x120, mispredict_count=1; the following cycle's input is discarded.
REQ-033 SHALL cover: COND, cmp_res=0, pred_taken=0, pc=0x200 -> no redirect, out_link=0x204, branch_count+1.
REQ-034 SHALL cover: JALR, rs1=0x1003, imm=0 -> target 0x1002, misaligned_o=1, redirect_o=0.
REQ-035 SHALL cover: out_ready_i held 0 for 3 cycles with valid output -> outputs stable, in_ready_o=0, no acceptance; release -> next instruction accepted the same cycle.
REQ-036 SHALL cover: reset_ni pulsed low during FLUSH -> all outputs 0 immediately, and counters 0; after release, a JAL at pc=0xFFFFFFFC with imm=4 gives target 0x0 and out_link 0x0.
